// File: rtl/afifo_wr_burst_if.sv
// Write-side burst bus: upstream valid/ready byte stream plus FIFO write port and occupancy.
// master = packet source / FIFO model side, slave = the burst scheduler.
interface afifo_wr_burst_if #(
  parameter int BITWID  = 8,
  parameter int DEEPWID = 3
);
  logic               s_valid;
  logic               s_ready;
  logic [BITWID-1:0]  s_data;
  logic               s_last;
  logic               fifo_full;
  logic [DEEPWID:0]   fifo_wr_num;
  logic               wr;
  logic [BITWID-1:0]  wr_dat;

  modport master (
    output s_valid, s_data, s_last, fifo_full, fifo_wr_num,
    input  s_ready, wr, wr_dat
  );

  modport slave (
    input  s_valid, s_data, s_last, fifo_full, fifo_wr_num,
    output s_ready, wr, wr_dat
  );
endinterface

// File: rtl/afifo_wr_burst.sv
// Write-domain burst scheduler: only opens a burst when the FIFO has room for BURST_LEN words.
// Optional macro AFIFO_WR_PAD_EN pads short packets with zero words up to BURST_LEN.
module afifo_wr_burst #(
  parameter int BITWID    = 8,
  parameter int DEEPWID   = 3,
  parameter int DEEP      = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              wr_clk,
  input  logic              wr_rst_n,
  afifo_wr_burst_if.slave   bus,
  output logic              busy,
  output logic [15:0]       burst_cnt,
  output logic              ovf_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
`ifdef AFIFO_WR_PAD_EN
    , S_PAD = 2'd3
`endif
  } state_e;

  localparam logic [DEEPWID+1:0] DEEP_W    = (DEEPWID+2)'(DEEP);
  localparam logic [DEEPWID+1:0] BURST_W   = (DEEPWID+2)'(BURST_LEN);
  localparam logic [DEEPWID:0]   LAST_BEAT = (DEEPWID+1)'(BURST_LEN - 1);

  state_e              state_q, state_d;
  logic [DEEPWID:0]    beat_q, beat_d;
  logic                wr_q, wr_d;
  logic [BITWID-1:0]   wr_dat_q, wr_dat_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                ovf_q, ovf_d;

  logic [DEEPWID+1:0]  free_raw_s;
  logic [DEEPWID+1:0]  free_s;
  logic                room_s;
  logic                s_ready_s;
  logic                busy_s;
  logic                accept_s;
  logic                last_beat_s;

  // The in-flight write is not yet in fifo_wr_num, so it is taken off the free count here.
  assign free_raw_s  = DEEP_W - {1'b0, bus.fifo_wr_num} - {{(DEEPWID+1){1'b0}}, wr_q};
  assign free_s      = free_raw_s[DEEPWID+1] ? '0 : free_raw_s;
  assign room_s      = (free_s >= BURST_W) && !bus.fifo_full;
  assign accept_s    = (state_q == S_BURST) && bus.s_valid && s_ready_s;
  assign last_beat_s = (beat_q == LAST_BEAT);

  // State and datapath registers
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      wr_q     <= 1'b0;
      wr_dat_q <= '0;
      cnt_q    <= 16'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      wr_q     <= wr_d;
      wr_dat_q <= wr_dat_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    wr_d     = 1'b0;
    wr_dat_d = wr_dat_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | ((state_q == S_BURST) && bus.fifo_full);
    case (state_q)
      S_IDLE: begin
        if (bus.s_valid) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (room_s) begin
          state_d = S_BURST;
          beat_d  = '0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_BURST: begin
        if (accept_s) begin
          wr_d     = 1'b1;
          wr_dat_d = bus.s_data;
          beat_d   = beat_q + (DEEPWID+1)'(1);
          if (last_beat_s) begin
            cnt_d   = cnt_q + 16'd1;
            state_d = S_IDLE;
          end else if (bus.s_last) begin
`ifdef AFIFO_WR_PAD_EN
            state_d = S_PAD;
`else
            cnt_d   = cnt_q + 16'd1;
            state_d = S_IDLE;
`endif
          end else begin
            state_d = S_BURST;
          end
        end else begin
          state_d = S_BURST;
        end
      end
`ifdef AFIFO_WR_PAD_EN
      // Room for the full burst was reserved at start, so padding never waits on fifo_full.
      S_PAD: begin
        wr_d     = 1'b1;
        wr_dat_d = '0;
        beat_d   = beat_q + (DEEPWID+1)'(1);
        if (last_beat_s) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = S_IDLE;
        end else begin
          state_d = S_PAD;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake and status decode from the current state only
  always_comb begin
    s_ready_s = 1'b0;
    busy_s    = 1'b1;
    case (state_q)
      S_IDLE:  busy_s    = 1'b0;
      S_WAIT:  s_ready_s = 1'b0;
      S_BURST: s_ready_s = !bus.fifo_full;
      default: s_ready_s = 1'b0;
    endcase
  end

  assign bus.s_ready = s_ready_s;
  assign bus.wr      = wr_q;
  assign bus.wr_dat  = wr_dat_q;
  assign busy        = busy_s;
  assign burst_cnt   = cnt_q;
  assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_afifo_wr_burst.sv
// Directed bench for afifo_wr_burst: a BURST_LEN=4 instance and a BURST_LEN=1 instance,
// with write data checked against per-instance expected-word queues.
module tb_afifo_wr_burst;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  afifo_wr_burst_if #(.BITWID(8), .DEEPWID(3)) aif ();
  afifo_wr_burst_if #(.BITWID(8), .DEEPWID(3)) bif ();

  logic        busy_a, ovf_a, busy_b, ovf_b;
  logic [15:0] cnt_a, cnt_b;

  afifo_wr_burst #(.BITWID(8), .DEEPWID(3), .DEEP(8), .BURST_LEN(4)) dut_a (
    .wr_clk(clk), .wr_rst_n(rst_n), .bus(aif),
    .busy(busy_a), .burst_cnt(cnt_a), .ovf_err(ovf_a)
  );

  afifo_wr_burst #(.BITWID(8), .DEEPWID(3), .DEEP(8), .BURST_LEN(1)) dut_b (
    .wr_clk(clk), .wr_rst_n(rst_n), .bus(bif),
    .busy(busy_b), .burst_cnt(cnt_b), .ovf_err(ovf_b)
  );

  int          vec  = 0;
  int          errs = 0;
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic [7:0]  ea, eb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop for each write strobe seen outside reset
  always @(negedge clk) begin
    if (rst_n === 1'b1 && aif.wr === 1'b1) begin
      if (qa.size() == 0) begin
        check("a_unexpected_wr", 32'd1, 32'd0);
      end else begin
        ea = qa.pop_front();
        check("a_wr_dat", {24'd0, aif.wr_dat}, {24'd0, ea});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bif.wr === 1'b1) begin
      if (qb.size() == 0) begin
        check("b_unexpected_wr", 32'd1, 32'd0);
      end else begin
        eb = qb.pop_front();
        check("b_wr_dat", {24'd0, bif.wr_dat}, {24'd0, eb});
      end
    end
  end

  // Present one word and hold it until accepted; returns at posedge+1 of the accept.
  task automatic send(input bit sel, input logic [7:0] d, input bit last, output int waits);
    bit acc;
    acc   = 1'b0;
    waits = 0;
    if (sel) begin
      bif.s_valid = 1'b1; bif.s_data = d; bif.s_last = last;
    end else begin
      aif.s_valid = 1'b1; aif.s_data = d; aif.s_last = last;
    end
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      if ((sel ? bif.s_ready : aif.s_ready) === 1'b1) acc = 1'b1;
      else waits++;
    end
    if (!acc) begin
      vec++;
      errs++;
      $error("FAIL send_timeout observed=no_accept expected=accept data=%0h", d);
    end else if (sel) begin
      qb.push_back(d);
    end else begin
      qa.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input bit sel, input string tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if ((sel ? busy_b : busy_a) === 1'b0) done = 1'b1;
    end
    check(tag, {31'd0, (sel ? busy_b : busy_a)}, 32'd0);
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    aif.s_valid = 1'b0; aif.s_data = 8'h00; aif.s_last = 1'b0;
    aif.fifo_full = 1'b0; aif.fifo_wr_num = 4'd0;
    bif.s_valid = 1'b0; bif.s_data = 8'h00; bif.s_last = 1'b0;
    bif.fifo_full = 1'b0; bif.fifo_wr_num = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr",      {31'd0, aif.wr},      32'd0);
    check("rst_wr_dat",  {24'd0, aif.wr_dat},  32'd0);
    check("rst_s_ready", {31'd0, aif.s_ready}, 32'd0);
    check("rst_busy",    {31'd0, busy_a},      32'd0);
    check("rst_cnt",     {16'd0, cnt_a},       32'd0);
    check("rst_ovf",     {31'd0, ovf_a},       32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two back-to-back bursts of 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 8'h10 + 8'(i), (i == 7), w);
      if (i == 4) check("burst_gap_ge2", {31'd0, (w >= 2)}, 32'd1);
    end
    aif.s_valid = 1'b0;
    wait_idle(1'b0, "idle_after_8");
    check("cnt_after_8", {16'd0, cnt_a}, 32'd2);

    // Not enough room with occupancy 5; start one cycle after it drops to 4
    aif.fifo_wr_num = 4'd5;
    aif.s_valid = 1'b1; aif.s_data = 8'h30; aif.s_last = 1'b0;
    repeat (5) @(negedge clk);
    check("wait_s_ready", {31'd0, aif.s_ready}, 32'd0);
    check("wait_busy",    {31'd0, busy_a},      32'd1);
    @(posedge clk);
    #1;
    aif.fifo_wr_num = 4'd4;
    @(posedge clk);
    @(negedge clk);
    check("room_s_ready", {31'd0, aif.s_ready}, 32'd1);
    qa.push_back(8'h30);
    @(posedge clk);
    #1;
    send(1'b0, 8'h31, 1'b0, w);
    send(1'b0, 8'h32, 1'b0, w);
    send(1'b0, 8'h33, 1'b1, w);
    aif.s_valid = 1'b0;
    aif.fifo_wr_num = 4'd0;
    wait_idle(1'b0, "idle_after_room");
    check("cnt_after_room", {16'd0, cnt_a}, 32'd3);

    // Short packet
    send(1'b0, 8'hA1, 1'b0, w);
    send(1'b0, 8'hA2, 1'b1, w);
    aif.s_valid = 1'b0;
`ifdef AFIFO_WR_PAD_EN
    qa.push_back(8'h00);
    qa.push_back(8'h00);
`endif
    wait_idle(1'b0, "idle_after_short");
    check("cnt_after_short", {16'd0, cnt_a}, 32'd4);
    repeat (2) @(negedge clk);
    check("short_drained", qa.size(), 32'd0);

    // fifo_full for 3 cycles mid-burst
    send(1'b0, 8'h40, 1'b0, w);
    send(1'b0, 8'h41, 1'b0, w);
    aif.s_valid = 1'b0;
    @(posedge clk);
    #1;
    aif.fifo_full = 1'b1;
    aif.s_valid = 1'b1; aif.s_data = 8'h42; aif.s_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_s_ready", {31'd0, aif.s_ready}, 32'd0);
      check("full_wr",      {31'd0, aif.wr},      32'd0);
      @(posedge clk);
      #1;
    end
    aif.fifo_full = 1'b0;
    check("ovf_set", {31'd0, ovf_a}, 32'd1);
    send(1'b0, 8'h42, 1'b0, w);
    send(1'b0, 8'h43, 1'b0, w);
    aif.s_valid = 1'b0;
    wait_idle(1'b0, "idle_after_full");
    check("cnt_after_full", {16'd0, cnt_a}, 32'd5);
    check("ovf_sticky",     {31'd0, ovf_a}, 32'd1);

    // Reset after the second word of a burst
    send(1'b0, 8'h50, 1'b0, w);
    send(1'b0, 8'h51, 1'b0, w);
    #2;
    rst_n = 1'b0;
    #1;
    qa.delete();
    check("mid_rst_wr",      {31'd0, aif.wr},      32'd0);
    check("mid_rst_s_ready", {31'd0, aif.s_ready}, 32'd0);
    check("mid_rst_busy",    {31'd0, busy_a},      32'd0);
    check("mid_rst_cnt",     {16'd0, cnt_a},       32'd0);
    check("mid_rst_ovf",     {31'd0, ovf_a},       32'd0);
    aif.s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, 8'h60 + 8'(i), (i == 3), w);
    aif.s_valid = 1'b0;
    wait_idle(1'b0, "idle_after_rst");
    check("cnt_after_rst", {16'd0, cnt_a}, 32'd1);

    // BURST_LEN=1 instance: every word is its own burst
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 8'h70 + 8'(i), (i == 2), w);
      @(negedge clk);
      check("b1_wr_latency", {31'd0, bif.wr}, 32'd1);
    end
    bif.s_valid = 1'b0;
    wait_idle(1'b1, "b1_idle");
    check("b1_cnt", {16'd0, cnt_b}, 32'd3);

    repeat (3) @(negedge clk);
    check("a_queue_empty", qa.size(), 32'd0);
    check("b_queue_empty", qb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/afifo_wr_burst.md
# afifo_wr_burst

Write-side burst scheduler for the asynchronous FIFO, running entirely in the write clock domain. It accepts a valid/ready byte stream with packet framing and drives the FIFO write port (`wr`/`wr_dat`). It starts a burst only when the FIFO reports room for a whole burst, so a burst of `BURST_LEN` words is never split by back-pressure. It sits between the upstream packet source and the FIFO write interface.

## Interface
Parameters:
- `BITWID`, 8, data word width.
- `DEEPWID`, 3, FIFO address width.
- `DEEP`, 8, FIFO depth in words; must equal 2^`DEEPWID`.
- `BURST_LEN`, 4, words per burst; legal range 1..`DEEP`.

Ports:
- `wr_clk`, in, 1, write-domain clock.
- `wr_rst_n`, in, 1, reset; asynchronous, active-low.
- `s_valid`, in, 1, upstream word valid.
- `s_ready`, out, 1, upstream word accepted when `s_valid & s_ready`.
- `s_data`, in, `BITWID`, upstream word.
- `s_last`, in, 1, last word of packet; qualified by `s_valid`.
- `fifo_full`, in, 1, FIFO full flag.
- `fifo_wr_num`, in, `DEEPWID+1`, FIFO occupancy as seen in the write domain (0..`DEEP`).
- `wr`, out, 1, FIFO write strobe; registered.
- `wr_dat`, out, `BITWID`, FIFO write data; registered.
- `busy`, out, 1, high in every state except IDLE.
- `burst_cnt`, out, 16, number of completed bursts; wraps at 2^16.
- `ovf_err`, out, 1, sticky error flag: `fifo_full` was seen while in BURST.

## Operation
- Free space: `free = DEEP - fifo_wr_num - wr`, computed in `DEEPWID+2` bits.
  - A negative result is clamped to 0.
  - Subtracting `wr` accounts for the write in flight that `fifo_wr_num` does not yet include.
- States:
  - **IDLE**: `s_ready=0`. If `s_valid`, move to WAIT.
  - **WAIT**: `s_ready=0`. If `free >= BURST_LEN` and `!fifo_full`, move to BURST and clear the beat counter `beat` (width `DEEPWID+1`).
  - **BURST**: `s_ready = !fifo_full`. On each accepted word: capture `wr_dat <= s_data`, set `wr <= 1`, and increment `beat`.
    - Burst end is an accept with `beat == BURST_LEN-1`, or an accept with `s_last=1`.
    - On burst end: increment `burst_cnt` and return to IDLE. With padding enabled, an early `s_last` goes to PAD instead (see Configuration).
  - **PAD**: exists only with `AFIFO_WR_PAD_EN`; see Configuration.
- `wr` is 0 in any cycle with no accept.
- `wr_dat` holds its last value when `wr=0`.
- `fifo_full` during BURST:
  - Stall, holding state and `beat`.
  - Set `ovf_err`; it stays set until reset.
- An accept with `s_last` and `beat == BURST_LEN-1` in the same cycle is a single normal burst end. It never enters PAD.
- `s_valid` dropping mid-burst stalls BURST. There is no timeout.
- `BURST_LEN=1`: every accept ends a burst, and `burst_cnt` increments per word.

## Timing
- Reset values: state IDLE; `s_ready=0`, `wr=0`, `wr_dat=0`, `busy=0`, `burst_cnt=0`, `ovf_err=0`, `beat=0`.
- Latency: an accept in cycle t gives `wr=1` with that word on `wr_dat` in cycle t+1.
- Burst start: `s_valid` rising in IDLE gives WAIT at t+1; `s_ready` rises at t+2 at the earliest.
- Back-to-back bursts: BURST → IDLE → WAIT → BURST, i.e. at least 2 bubble cycles between bursts.
- `s_ready` is combinational from state and `fifo_full`. It does not depend on `s_valid`.
- Reset asserted mid-burst:
  - All outputs return to reset values immediately (asynchronously).
  - Words already written stay in the FIFO.
  - A partial burst is neither completed nor counted.

## Configuration
- Macro: `AFIFO_WR_PAD_EN`.
- Defined: an accept with `s_last` and `beat < BURST_LEN-1` moves to PAD.
  - In PAD: `s_ready=0`, and the block writes `wr=1`, `wr_dat=0` each cycle until `BURST_LEN` words in total have been written.
  - It then increments `burst_cnt` and returns to IDLE.
  - Every burst is therefore exactly `BURST_LEN` words.
- Not defined: the PAD state and its logic are absent. An early `s_last` ends a short burst, which still increments `burst_cnt`.

## Test plan
- Defaults, `fifo_wr_num=0`, 8 words 0x10..0x17 with `s_last` on 0x17:
  - `wr` pulses carry 0x10..0x13, then 0x14..0x17.
  - At least 2 idle cycles between the two bursts.
  - `burst_cnt` = 2.
- `fifo_wr_num=5` held, `s_valid=1`: block stays in WAIT and `s_ready=0`. Drop `fifo_wr_num` to 4 → burst of 4 words starts, with `s_ready` high 1 cycle after the drop.
- 2-word packet 0xA1, 0xA2 with `s_last` on 0xA2:
  - Without the macro: 2 writes, then IDLE, `burst_cnt` = 1.
  - With `AFIFO_WR_PAD_EN`: writes 0xA1, 0xA2, 0x00, 0x00, `burst_cnt` = 1.
- Force `fifo_full=1` for 3 cycles mid-BURST:
  - `s_ready=0` and no `wr` for those 3 cycles.
  - `ovf_err` = 1 and stays 1 after `fifo_full` clears.
  - The burst resumes with `beat` preserved.
- Assert `wr_rst_n=0` after the 2nd word of a burst:
  - `wr`, `s_ready`, `busy`, `burst_cnt`, `ovf_err` all 0 immediately.
  - After release, a new 4-word burst completes normally.
- `BURST_LEN=1`, 3 words: 3 writes, each 1 cycle after its accept; `burst_cnt` = 3.
